prio_encoder_rr: RTL and testbench

//  Parametrised N-to-log2(N) request encoder with registered output and valid/ready handshake.
//  Two modes, selected per encode: fixed priority or round-robin.

---
 rtl/prio_encoder_rr.sv | 127 ++++++++++++
 tb/tb_prio_encoder_rr.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: N-to-log2(N) request encoder, fixed or round-robin per encode,
// registered result held until accepted over a valid/ready handshake.
// Ports: clk, rst_n (async, active-low), in_req[N], in_mode (0 fixed, 1 rr),
//   out_valid, out_ready, out_idx[W], out_multi,
//   out_onehot[N] (only when PRIO_ENC_ONEHOT_EN is defined).
module prio_encoder_rr #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_req,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_multi
`ifdef PRIO_ENC_ONEHOT_EN
  ,
  output logic [N-1:0] out_onehot
`endif
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         multi_q, multi_d;
  logic         mode_q, mode_d;

  logic         accept;
  logic         encode;
  logic [W-1:0] ptr_eff;
  logic [W-1:0] fp_idx;
  logic [W-1:0] rr_idx;
  logic [2*N-1:0] rot;
  logic [W:0]   sum;

  assign accept = (state_q == HOLD) && out_ready;
  assign encode = (|in_req) && ((state_q == IDLE) || out_ready);

  // A back-to-back rr encode must already see the pointer advanced
  // by the result being accepted in the same cycle.
  always_comb begin
    ptr_eff = ptr_q;
    if (accept && mode_q) begin
      if (idx_q == W'(N - 1)) ptr_eff = '0;
      else                    ptr_eff = idx_q + 1'b1;
    end
  end

  always_comb begin
    fp_idx = '0;
    for (int i = 0; i < N; i++)
      if (in_req[i]) fp_idx = W'(i);
  end

  // Rotate so bit 0 is the pointer slot; the lowest set bit
  // of the rotated vector is the first request at or after ptr.
  always_comb begin
    rot    = {in_req, in_req} >> ptr_eff;
    rr_idx = '0;
    sum    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, ptr_eff} + (W+1)'(i);
        if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
        rr_idx = sum[W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    multi_d = multi_q;
    mode_d  = mode_q;
    ptr_d   = ptr_eff;
    if (encode) begin
      state_d = HOLD;
      idx_d   = in_mode ? rr_idx : fp_idx;
      multi_d = |(in_req & (in_req - 1'b1));
      mode_d  = in_mode;
    end else if (accept) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      multi_q <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      multi_q <= multi_d;
      mode_q  <= mode_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_idx   = idx_q;
  assign out_multi = multi_q;

`ifdef PRIO_ENC_ONEHOT_EN
  logic [N-1:0] onehot_q, onehot_d;

  always_comb begin
    onehot_d = onehot_q;
    if (encode)      onehot_d = {{(N-1){1'b0}}, 1'b1} << idx_d;
    else if (accept) onehot_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) onehot_q <= '0;
    else        onehot_q <= onehot_d;
  end

  assign out_onehot = onehot_q;
`endif

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb_prio_encoder_rr: directed and randomized checks of prio_encoder_rr
// (N=4 main instance, N=5 instance for the non-power-of-2 case).
module tb_prio_encoder_rr;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       mode;
  logic       ready;
  logic       valid;
  logic [1:0] idx;
  logic       multi;
  logic [4:0] req5;
  logic       mode5;
  logic       ready5;
  logic       valid5;
  logic [2:0] idx5;
  logic       multi5;
`ifdef PRIO_ENC_ONEHOT_EN
  logic [3:0] onehot;
  logic [4:0] onehot5;
`endif

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(req), .in_mode(mode),
    .out_valid(valid), .out_ready(ready), .out_idx(idx),
    .out_multi(multi)
`ifdef PRIO_ENC_ONEHOT_EN
    , .out_onehot(onehot)
`endif
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_req(req5), .in_mode(mode5),
    .out_valid(valid5), .out_ready(ready5), .out_idx(idx5),
    .out_multi(multi5)
`ifdef PRIO_ENC_ONEHOT_EN
    , .out_onehot(onehot5)
`endif
  );

  int checks = 0;
  int passed = 0;

  // Reference model of the N=4 instance
  bit m_valid;
  int m_idx;
  int m_multi;
  int m_ptr;
  bit m_mode;

  task automatic model_reset();
    m_valid = 0; m_idx = 0; m_multi = 0; m_ptr = 0; m_mode = 0;
  endtask

  // Evaluate the rules on the current inputs, clock once, commit.
  task automatic step();
    bit acc, enc, nv, nm;
    int p, w, nmul;
    acc = m_valid && ready;
    enc = (req != 0) && (!m_valid || ready);
    p = (acc && m_mode) ? (m_idx + 1) % N : m_ptr;
    w = m_idx; nv = m_valid; nm = m_mode; nmul = m_multi;
    if (enc) begin
      nv = 1; nm = mode;
      nmul = ($countones(req) > 1) ? 1 : 0;
      if (mode) begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(p + k) % N]) w = (p + k) % N;
      end else begin
        for (int i = 0; i < N; i++)
          if (req[i]) w = i;
      end
    end else if (acc) begin
      nv = 0;
    end
    @(posedge clk);
    m_valid = nv; m_idx = w; m_multi = nmul; m_ptr = p; m_mode = nm;
    #1;
  endtask

  task automatic do_reset();
    req = 0; mode = 0; ready = 0;
    req5 = 0; mode5 = 0; ready5 = 0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (valid !== 1'b0 || idx !== 2'd0 || multi !== 1'b0) begin
      $display("FAIL reset_init: valid=%b idx=%0d multi=%b want 0 0 0",
               valid, idx, multi);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0; req = 4'b0100; ready = 0;
    step();
    checks++;
    if (valid !== 1'b1 || idx !== 2'd2) begin
      $display("FAIL reset_pre_hold: valid=%b idx=%0d want 1 2", valid, idx);
    end else passed++;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (valid !== 1'b0 || idx !== 2'd0 || multi !== 1'b0) begin
      $display("FAIL reset_async: valid=%b idx=%0d multi=%b want 0 0 0",
               valid, idx, multi);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    mode = 1; req = 4'b1111;
    step();
    checks++;
    if (valid !== 1'b1 || idx !== 2'd0 || multi !== 1'b1) begin
      $display("FAIL reset_rr_first: valid=%b idx=%0d multi=%b want 1 0 1",
               valid, idx, multi);
    end else passed++;
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 0; req = 4'b0110; ready = 0;
    step();
    checks++;
    if (valid !== 1'b1 || idx !== 2'd2 || multi !== 1'b1) begin
      $display("FAIL fixed_encode: valid=%b idx=%0d multi=%b want 1 2 1",
               valid, idx, multi);
    end else passed++;
    req = 4'b0001;
    mode = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (valid !== 1'b1 || idx !== 2'd2 || multi !== 1'b1) begin
        $display("FAIL fixed_hold: valid=%b idx=%0d multi=%b want 1 2 1",
                 valid, idx, multi);
      end else passed++;
    end
    ready = 1; mode = 0;
    step();
    checks++;
    if (valid !== 1'b1 || idx !== 2'd0 || multi !== 1'b0) begin
      $display("FAIL fixed_b2b: valid=%b idx=%0d multi=%b want 1 0 0",
               valid, idx, multi);
    end else passed++;
  endtask

  task automatic test_rr_rotation();
    do_reset();
    mode = 1; req = 4'b1111; ready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (valid !== 1'b1 || idx !== 2'(i % 4)) begin
        $display("FAIL rr_rotate[%0d]: valid=%b idx=%0d want 1 %0d",
                 i, valid, idx, i % 4);
      end else passed++;
    end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    mode = 1; req = 4'b0100; ready = 0;
    step();
    ready = 1; req = 4'b0010;
    step();
    checks++;
    if (valid !== 1'b1 || idx !== 2'd1 || multi !== 1'b0) begin
      $display("FAIL rr_wrap: valid=%b idx=%0d multi=%b want 1 1 0",
               valid, idx, multi);
    end else passed++;
    req = 4'b1111;
    step();
    checks++;
    if (valid !== 1'b1 || idx !== 2'd2) begin
      $display("FAIL rr_ptr_after: valid=%b idx=%0d want 1 2", valid, idx);
    end else passed++;
  endtask

  task automatic test_drain();
    do_reset();
    mode = 0; req = 4'b0001; ready = 1;
    step();
    req = 0;
    step();
    checks++;
    if (valid !== 1'b0) begin
      $display("FAIL drain: valid=%b want 0", valid);
    end else passed++;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (valid !== 1'b0) begin
        $display("FAIL empty_idle[%0d]: valid=%b want 0", i, valid);
      end else passed++;
    end
  endtask

  task automatic test_n5();
    do_reset();
    mode5 = 1; req5 = 5'b01000; ready5 = 0;
    step();
    checks++;
    if (valid5 !== 1'b1 || idx5 !== 3'd3) begin
      $display("FAIL n5_first: valid=%b idx=%0d want 1 3", valid5, idx5);
    end else passed++;
    ready5 = 1; req5 = 5'b10000;
    step();
    checks++;
    if (valid5 !== 1'b1 || idx5 !== 3'd4 || multi5 !== 1'b0) begin
      $display("FAIL n5_top: valid=%b idx=%0d multi=%b want 1 4 0",
               valid5, idx5, multi5);
    end else passed++;
`ifdef PRIO_ENC_ONEHOT_EN
    checks++;
    if (onehot5 !== 5'b10000) begin
      $display("FAIL n5_onehot: got %b want 10000", onehot5);
    end else passed++;
`endif
    req5 = 5'b11111;
    step();
    checks++;
    if (valid5 !== 1'b1 || idx5 !== 3'd0 || multi5 !== 1'b1) begin
      $display("FAIL n5_wrap: valid=%b idx=%0d multi=%b want 1 0 1",
               valid5, idx5, multi5);
    end else passed++;
    ready5 = 1; req5 = 0;
    step();
    checks++;
    if (valid5 !== 1'b0) begin
      $display("FAIL n5_drain: valid=%b want 0", valid5);
    end else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req   = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req = 0;
      mode  = 1'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      step();
      checks++;
      if (valid !== m_valid) begin
        $display("FAIL rand_valid[%0d]: got %b want %b", c, valid, m_valid);
      end else passed++;
      if (m_valid) begin
        checks++;
        if (idx !== 2'(m_idx) || multi !== 1'(m_multi)) begin
          $display("FAIL rand_idx[%0d]: idx=%0d multi=%b want %0d %0d",
                   c, idx, multi, m_idx, m_multi);
        end else passed++;
      end
`ifdef PRIO_ENC_ONEHOT_EN
      checks++;
      if (onehot !== (m_valid ? 4'(1 << m_idx) : 4'd0)) begin
        $display("FAIL rand_onehot[%0d]: got %b", c, onehot);
      end else passed++;
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req = 0; mode = 0; ready = 0;
    req5 = 0; mode5 = 0; ready5 = 0;
    model_reset();
    #1;
    test_reset();
    test_fixed();
    test_rr_rotation();
    test_rr_wrap();
    test_drain();
    test_n5();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
